// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter state: nobody owns the write port, or a producer holds a burst.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Default FIFO depth the arbiter throttles against.
    localparam int DEPTH_DEFAULT = 8;

    // Saturation value of the per-owner beat counter (4-bit register).
    localparam int BEAT_SAT = 15;

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted request at or after base, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // base + offset, wrapped into 0..N-1 (base is always below N).
    function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan requests in circular order starting at base; keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // it unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[add_mod(base, i)]) begin
                valid = 1'b1;
                idx   = add_mod(base, i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts feeding one FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DW-1:0]          req_data,
    output logic [N_REQ-1:0]             gnt,
    output logic                         fifo_wr,
    output logic [DW-1:0]                fifo_di,
    input  logic [cnt_width(DEPTH)-1:0]  fifo_cnt,
    output logic [$clog2(N_REQ)-1:0]     owner,
    output logic                         busy
);

    localparam int IW = $clog2(N_REQ);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   own, own_nx;
    logic [3:0]      beats, beats_nx;
    logic            fifo_wr_nx;
    logic [DW-1:0]   fifo_di_nx;

    logic            space;
    logic            keep;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   pick_base;
    logic [IW-1:0]   k;
    logic            accept;
    logic [N_REQ-1:0] others;

    // Index after i, wrapping N_REQ-1 back to 0.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    // Count the in-flight write as already occupying a slot; reads are ignored.
    assign space = (int'(fifo_cnt) + int'(fifo_wr)) < DEPTH;

    // In IDLE search from ptr; in OWN the hand-off search starts after the owner.
    assign pick_base = (state == OWN) ? next_idx(own) : ptr;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req),
        .base  (pick_base),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // The owner keeps the port while under its burst limit or while uncontested.
    assign others = req & ~(N_REQ'(1) << own);
    assign keep   = (state == OWN) && req[own] &&
                    ((int'(beats) < MAX_BURST) || (others == '0));
    assign k      = keep ? own : pick_idx;
    assign accept = !rst && space && (keep || pick_valid);
    assign gnt    = accept ? (N_REQ'(1) << k) : '0;

    assign busy   = (state == OWN);
    assign owner  = busy ? own : '0;

    // Next-state, burst bookkeeping and FIFO write-port values.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        own_nx     = own;
        beats_nx   = beats;
        fifo_wr_nx = accept;
        fifo_di_nx = accept ? req_data[int'(k)*DW +: DW] : fifo_di;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = OWN;
                    own_nx   = k;
                    beats_nx = 4'd1;
                end
            end
            OWN: begin
                if (req == '0) begin
                    state_nx = IDLE;
                    ptr_nx   = next_idx(own);
                end else if (accept) begin
                    if (keep) begin
                        if (int'(beats) != BEAT_SAT) beats_nx = beats + 4'd1;
                    end else begin
                        own_nx   = k;
                        beats_nx = 4'd1;
                        ptr_nx   = next_idx(own);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            own     <= '0;
            beats   <= '0;
            fifo_wr <= 1'b0;
            fifo_di <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            own     <= own_nx;
            beats   <= beats_nx;
            fifo_wr <= fifo_wr_nx;
            fifo_di <= fifo_di_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (burst 4 and burst 1 instances).
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  fifo_cnt;

    logic [3:0]  gnt,  gnt1;
    logic        fifo_wr, fifo_wr1;
    logic [7:0]  fifo_di, fifo_di1;
    logic [1:0]  owner, owner1;
    logic        busy, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.N_REQ(4), .DW(8), .DEPTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_wr(fifo_wr), .fifo_di(fifo_di), .fifo_cnt(fifo_cnt),
        .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.N_REQ(4), .DW(8), .DEPTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt1),
        .fifo_wr(fifo_wr1), .fifo_di(fifo_di1), .fifo_cnt(fifo_cnt),
        .owner(owner1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        fifo_cnt = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        fifo_cnt = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", i, gnt);
            end
            n_checks++;
            if (fifo_wr !== 1'b0) begin
                n_fail++; $display("FAIL reset_fifo_wr cyc%0d: got %b want 0", i, fifo_wr);
            end
            n_checks++;
            if (fifo_di !== 8'h00) begin
                n_fail++; $display("FAIL reset_fifo_di cyc%0d: got %h want 00", i, fifo_di);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", gnt);
        end
        n_checks++;
        if (busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b owner=%0d want 0/0", busy, owner);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int rr_idx[5];
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        rr_idx = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_g = 4'b0001 << rr_idx[i];
            n_checks++;
            if (gnt1 !== exp_g) begin
                n_fail++; $display("FAIL rr_gnt step%0d: got %b want %b", i, gnt1, exp_g);
            end
            if (i > 0) begin
                exp_d = 8'hA0 + 8'(rr_idx[i-1]);
                n_checks++;
                if (fifo_wr1 !== 1'b1 || fifo_di1 !== exp_d) begin
                    n_fail++;
                    $display("FAIL rr_data step%0d: got wr=%b di=%h want wr=1 di=%h", i, fifo_wr1, fifo_di1, exp_d);
                end
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (fifo_wr1 !== 1'b1 || fifo_di1 !== 8'hA0) begin
            n_fail++; $display("FAIL rr_data_last: got wr=%b di=%h want wr=1 di=a0", fifo_wr1, fifo_di1);
        end
        tick();
    endtask

    task automatic test_burst_limit();
        int bs_idx[9];
        logic [3:0] exp_g;
        bs_idx = '{2, 2, 2, 2, 3, 3, 3, 3, 2};
        do_reset();
        req = 4'b1100;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_g = 4'b0001 << bs_idx[i];
            n_checks++;
            if (gnt !== exp_g) begin
                n_fail++; $display("FAIL burst_gnt step%0d: got %b want %b", i, gnt, exp_g);
            end
            tick();
        end
        req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'b0100 || owner !== 2'd2) begin
                n_fail++; $display("FAIL burst_solo step%0d: got gnt=%b owner=%0d want 0100/2", i, gnt, owner);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        int         bp_cnt[6];
        logic [3:0] bp_gnt[6];
        logic       bp_wr[6];
        bp_cnt = '{6, 6, 7, 7, 8, 8};
        bp_gnt = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        bp_wr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            fifo_cnt = 4'(bp_cnt[i]);
            @(negedge clk);
            n_checks++;
            if (gnt !== bp_gnt[i] || fifo_wr !== bp_wr[i]) begin
                n_fail++;
                $display("FAIL bp step%0d cnt=%0d: got gnt=%b wr=%b want gnt=%b wr=%b", i, bp_cnt[i], gnt, fifo_wr, bp_gnt[i], bp_wr[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (busy !== 1'b1 || owner !== 2'd0) begin
                    n_fail++; $display("FAIL bp_hold: got busy=%b owner=%0d want 1/0", busy, owner);
                end
            end
            tick();
        end
        fifo_cnt = '0;
    endtask

    task automatic test_handoff_drop();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL ho_first: got %b want 0010", gnt);
        end
        tick();
        req = 4'b1010;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            n_fail++; $display("FAIL ho_keep: got gnt=%b owner=%0d want 0010/1", gnt, owner);
        end
        tick();
        req = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL ho_gnt: got %b want 1000", gnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (owner !== 2'd3 || dut.ptr !== 2'd2) begin
            n_fail++; $display("FAIL ho_owner_ptr: got owner=%0d ptr=%0d want 3/2", owner, dut.ptr);
        end
        n_checks++;
        if (fifo_wr !== 1'b1 || fifo_di !== 8'hA3) begin
            n_fail++; $display("FAIL ho_data: got wr=%b di=%h want 1/a3", fifo_wr, fifo_di);
        end
        tick();
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        req = 4'b0100;
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd2 || gnt !== 4'b0100) begin
            n_fail++; $display("FAIL mbr_burst: got busy=%b owner=%0d gnt=%b want 1/2/0100", busy, owner, gnt);
        end
        tick();
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++; $display("FAIL mbr_gnt_in_rst: got %b want 0000", gnt);
        end
        n_checks++;
        if (fifo_wr !== 1'b1) begin
            n_fail++; $display("FAIL mbr_inflight: got wr=%b want 1", fifo_wr);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.state !== IDLE || busy !== 1'b0 || owner !== 2'd0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL mbr_after: got state=%0d busy=%b owner=%0d wr=%b want 0/0/0/0", dut.state, busy, owner, fifo_wr);
        end
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL mbr_restart: got %b want 0001", gnt);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        fifo_cnt = '0;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_back_pressure();
        test_handoff_drop();
        test_mid_burst_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 8-entry × 8-bit FIFO among several producers. It grants at most one write per cycle, supports bounded bursts per producer, and drives the FIFO write port from registers. It throttles on the FIFO occupancy count, including the write it has in flight, so the FIFO never sees a write when it has no space. It sits between the producer blocks and the FIFO write side; the read side is untouched.

## Interface
- N_REQ, default 4: number of producers, 2..8.
- DW, default 8: data width.
- DEPTH, default 8: FIFO depth; the count width is $clog2(DEPTH+1).
- MAX_BURST, default 4: maximum consecutive beats one producer keeps the grant while others request; 1..15.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-producer request. Once high, a request is held with its data stable until granted.
- req_data  in  N_REQ*DW  flattened producer data; slice i = req_data[i*DW +: DW].
- gnt  out  N_REQ  one-hot, combinational. gnt[i] high means the beat is accepted at this edge.
- fifo_wr  out  1  registered FIFO write strobe.
- fifo_di  out  DW  registered FIFO write data.
- fifo_cnt  in  $clog2(DEPTH+1)  FIFO occupancy, valid at the current cycle.
- owner  out  $clog2(N_REQ)  index of the current burst owner; 0 when IDLE.
- busy  out  1  high when state is OWN.

## Operation
- Space rule: space = (fifo_cnt + fifo_wr) < DEPTH, using the registered fifo_wr. Reads are ignored here; this is conservative and reads only free space later.
- Accept rule: a beat is accepted when space is true, the selected req[k] is high, and gnt[k] is high. Only one beat is accepted per cycle.
- FIFO write on accept: at the same edge, fifo_wr <= 1 and fifo_di <= req_data[k]. With no accept, fifo_wr <= 0 and fifo_di holds its value.
- State machine, two states: IDLE and OWN. Registers: ptr (rotating priority base), own, beats (4 bits).
- IDLE: k = the first requester at or after ptr, in circular order. If the beat is accepted, go to OWN with own = k and beats = 1.
- OWN, selection: k = own if req[own] is high and either beats < MAX_BURST or no other req is high. Otherwise k = the first requester after own, in circular order.
- OWN, k = own and accepted: beats increments and saturates at 15.
- OWN, k ≠ own and accepted: own = k, beats = 1, ptr = old own + 1 (mod N_REQ).
- OWN, no req high: go to IDLE with ptr = own + 1.
- OWN, req high but no space: stay in OWN, hold own and beats, all gnt low.
- Fairness: once MAX_BURST beats are done, the grant passes to any other waiting requester. Worst-case wait is (N_REQ−1)·MAX_BURST accepted beats.
- A single requester with no competition may stream indefinitely.

## Timing
- Reset values: gnt = 0, fifo_wr = 0, fifo_di = 0, owner = 0, busy = 0, state = IDLE, ptr = 0, beats = 0.
- rst asserted mid-burst:
  - Next cycle has fifo_wr = 0.
  - No gnt during any rst cycle.
  - An in-flight write registered before rst still appears for its one cycle; the FIFO handles its own reset.
- Latency: gnt in cycle t leads to fifo_wr/fifo_di valid in cycle t+1. The FIFO stores the data at the end of cycle t+1, and fifo_cnt reflects it in t+2.
- Throughput: one beat per cycle while space holds.
- Full boundaries:
  - fifo_cnt = 7 with fifo_wr = 1 gives space = 0, so no gnt.
  - fifo_cnt = 7 with fifo_wr = 0 gives one grant.
- Wrap-around: ptr and own rotate modulo N_REQ, so index N_REQ−1 is followed by 0.

## Structure
- Package fifo_arb_pkg:
  - state enum {IDLE, OWN};
  - DEPTH default;
  - a function for the count width.
- Sub-module rr_pick: combinational rotating priority encoder. Inputs are req and base; outputs are a valid flag and the index. It is used for both IDLE selection and OWN hand-off (with base = own+1).
- Top level: state registers, space check, output registers.

## Test plan
- Reset: hold rst for 3 cycles with all req high -> gnt = 0, fifo_wr = 0, fifo_di = 0 throughout; first gnt[0] appears in the cycle after rst falls.
- Round-robin with MAX_BURST = 1: req = 4'b1111, fifo_cnt = 0 -> gnt sequence 0,1,2,3,0; fifo_di sequence matches req_data slices, each one cycle after its gnt.
- Burst limit: MAX_BURST = 4, req[2] and req[3] held high -> four gnt[2], then four gnt[3], then back to 2. With req[3] dropped, gnt[2] continues every cycle.
- Back-pressure:
  - fifo_cnt = 6, one req → a gnt in two consecutive cycles. In the second, fifo_cnt = 6 + fifo_wr = 1 → 7, under the limit.
  - Drive fifo_cnt = 7 with fifo_wr = 1 → gnt low.
  - Drive fifo_cnt = 8 → gnt low.
  - A write is never issued with count + in-flight ≥ 8.
- Hand-off on drop: owner 1 mid-burst (beats = 2) drops req while req[3] is high -> gnt[3] in the same cycle, owner = 3, ptr = 2.
- Mid-burst reset: rst during an OWN burst -> next cycle state = IDLE, busy = 0, owner = 0; after rst falls, arbitration restarts at index 0.
